keypad_bcd_entry: RTL and testbench
===================================

Name: keypad_bcd_entry

Overview:
- Scans a 4x4 matrix keypad and debounces presses.
- Builds a 4-digit BCD number from digit keys, with clear and backspace keys.
- Outputs ones/tens/hundred/thousand, which connect directly to the 7-segment display top's digit inputs.
- Forms the input side of the display path: it drives keypad columns outward and reads rows back, the mirror of the display's anode scan.

Parameters:
- CLK_DIV, 5000: clk cycles per scan tick (50 MHz -> 10 kHz); must be >= 2.
- DEBOUNCE_TICKS, 20: consecutive stable ticks required to accept a press and to accept a release; must be >= 1.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- row  input  4  keypad rows, active-low (pulled up), asynchronous to clk.
- col  output 4  keypad column drive, active-low, exactly one bit low at all times.
- key_code  output 4  code of the last accepted key; held until the next accepted key.
- key_valid  output 1  one-clk pulse when a key is accepted.
- ones  output 4  BCD digit 0.
- tens  output 4  BCD digit 1.
- hundred  output 4  BCD digit 2.
- thousand  output 4  BCD digit 3.

Behaviour:
- Reset (async, rst=1):
  - col=4'b1110.
  - key_code=0, key_valid=0, all digits=0.
  - Tick counter=0, debounce counter=0, FSM=SCAN.
  - Synchronizer flops preset to 4'b1111.
- Synchronizer:
  - row passes through 2 flops; rs is the synchronized value.
  - All decisions use rs only.
- Tick generator:
  - Free-running counter 0..CLK_DIV-1.
  - tick=1 for one clk when counter==CLK_DIV-1, then the counter wraps to 0.
  - The FSM acts only on tick cycles.
- Valid pattern: rs has exactly one bit low. Any other value (all-high or multi-low) counts as "no key".
- FSM states:
  - SCAN
    - Valid pattern on tick: latch the pattern into pat, set cnt=1, go DEBOUNCE. col is held.
    - Otherwise on tick: rotate col to the next column (1110->1101->1011->0111->1110).
  - DEBOUNCE
    - On tick with rs==pat: cnt++.
    - When cnt reaches DEBOUNCE_TICKS: accept the key, set cnt=0, go HELD.
    - On tick with rs!=pat: cnt=0, rotate col, go SCAN.
    - DEBOUNCE_TICKS=1: acceptance happens on the SCAN tick itself; skip DEBOUNCE.
  - HELD
    - On tick with rs==4'b1111: cnt++. When cnt reaches DEBOUNCE_TICKS: cnt=0, rotate col, go SCAN.
    - On tick with any other rs: cnt=0. Covers bounce or a second key; no new key is generated while in HELD.
- Key map (row r, active col c -> code):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E,0,F,D
- Accept action, all on the same clk edge:
  - key_valid=1 for exactly that cycle.
  - key_code updates.
  - Digit registers update as below.
- Digit update rules:
  - Code 0-9: shift left. thousand<=hundred, hundred<=tens, tens<=ones, ones<=code. The old thousand is discarded.
  - Code A (clear): all digits <= 0.
  - Code B (backspace): ones<=tens, tens<=hundred, hundred<=thousand, thousand<=0.
  - Codes C-F: key_valid and key_code update; digits unchanged.
- Digits are always in 0-9.
- A held key produces exactly one key_valid, with no auto-repeat.
- rst mid-operation (any state) returns to the reset values immediately; an in-progress press is dropped. A key still held after reset release is re-detected and accepted normally.

Test Plan (CLK_DIV=4, DEBOUNCE_TICKS=3):
- Reset, no key -> col cycles 1110,1101,1011,0111,1110 with one step every 4 clk; key_valid never pulses; digits=0.
- Hold row=1110 while col=1101, then release -> exactly one key_valid; key_code=2; ones=2, others 0. Hold for 50 ticks -> no further pulse.
- Press keys 1,2,3,4,5 in sequence (each held and released cleanly) -> after each press the digits read 0001, 0012, 0123, 1234, 2345 (thousand..ones).
- From 2345, press B then A -> after B: 0234; after A: 0000. key_code = 0xB then 0xA.
- Bounce: row low for 2 ticks, high for 1, then low steadily -> the first attempt aborts and col advances; acceptance occurs only after 3 consecutive stable ticks on a later scan pass; exactly one key_valid.
- Two rows low simultaneously (1100) -> no acceptance. Assert rst while in HELD -> all outputs 0 and col=1110 immediately. A key held through reset release is accepted exactly once.

Source files
------------

// File: rtl/keypad_bcd_entry_if.sv
// -----------------------------------------------------------------------------
// keypad_bcd_entry_if
//   Bundles the keypad matrix lines and the BCD entry outputs of
//   keypad_bcd_entry.
//
//   row       keypad rows, active-low, pulled up, asynchronous to clk
//   col       keypad column drive, active-low, exactly one bit low
//   key_code  code of the last accepted key
//   key_valid one-clk pulse when a key is accepted
//   ones      BCD digit 0
//   tens      BCD digit 1
//   hundred   BCD digit 2
//   thousand  BCD digit 3
//
//   master: the keypad entry block (reads row, drives everything else)
//   slave : the keypad / display side (drives row, reads everything else)
// -----------------------------------------------------------------------------
interface keypad_bcd_entry_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] hundred;
    logic [3:0] thousand;

    modport master (
        input  row,
        output col, key_code, key_valid, ones, tens, hundred, thousand
    );

    modport slave (
        output row,
        input  col, key_code, key_valid, ones, tens, hundred, thousand
    );
endinterface

// File: rtl/keypad_bcd_entry.sv
// -----------------------------------------------------------------------------
// keypad_bcd_entry
//   Scans a 4x4 active-low matrix keypad, debounces presses and releases, and
//   assembles a 4-digit BCD number from the accepted keys.
//   Digit keys shift in from the right, A clears, B deletes the last digit,
//   C-F are reported but leave the digits alone.
//
//   clk  input   system clock, rising edge
//   rst  input   asynchronous, active-high reset
//   kp   master  row in; col, key_code, key_valid, ones/tens/hundred/thousand out
//
//   CLK_DIV        clk cycles per scan tick (>= 2)
//   DEBOUNCE_TICKS stable ticks needed to accept a press and a release (>= 1)
// -----------------------------------------------------------------------------
module keypad_bcd_entry #(
    parameter int CLK_DIV        = 5000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    keypad_bcd_entry_if.master     kp
);

    localparam int TW = $clog2(CLK_DIV);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DB_DONE   = CW'(DEBOUNCE_TICKS);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HELD
    } state_e;

    // Index (0..3) of the low bit of a one-low pattern.
    function automatic logic [1:0] low_idx(input logic [3:0] p);
        case (p)
            4'b1101: low_idx = 2'd1;
            4'b1011: low_idx = 2'd2;
            4'b0111: low_idx = 2'd3;
            default: low_idx = 2'd0;
        endcase
    endfunction

    // Key legend as printed on the pad, indexed {row, col}.
    function automatic logic [3:0] key_lookup(input logic [3:0] row_pat,
                                              input logic [3:0] col_pat);
        case ({low_idx(row_pat), low_idx(col_pat)})
            4'h0: key_lookup = 4'h1;
            4'h1: key_lookup = 4'h2;
            4'h2: key_lookup = 4'h3;
            4'h3: key_lookup = 4'hA;
            4'h4: key_lookup = 4'h4;
            4'h5: key_lookup = 4'h5;
            4'h6: key_lookup = 4'h6;
            4'h7: key_lookup = 4'hB;
            4'h8: key_lookup = 4'h7;
            4'h9: key_lookup = 4'h8;
            4'hA: key_lookup = 4'h9;
            4'hB: key_lookup = 4'hC;
            4'hC: key_lookup = 4'hE;
            4'hD: key_lookup = 4'h0;
            4'hE: key_lookup = 4'hF;
            default: key_lookup = 4'hD;
        endcase
    endfunction

    // ---------------------------------------------------------------- state
    logic [3:0]    sync1_q, rs_q;
    logic [TW-1:0] tick_cnt_q;
    state_e        state_q, state_d;
    logic [3:0]    col_q, col_d;
    logic [3:0]    pat_q, pat_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    key_code_q;
    logic          key_valid_q;
    logic [3:0]    ones_q, tens_q, hundred_q, thousand_q;

    logic          tick;
    logic          rs_valid;
    logic [3:0]    col_rot;
    logic [CW-1:0] cnt_inc;
    logic          accept;
    logic [3:0]    accept_pat;
    logic [3:0]    accept_code;

    // Two-flop synchronizer; presets to "no key" so reset never looks pressed.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 4'b1111;
            rs_q    <= 4'b1111;
        end else begin
            sync1_q <= kp.row;
            rs_q    <= sync1_q;
        end
    end

    // Free-running scan tick divider.
    assign tick = (tick_cnt_q == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tick_cnt_q <= '0;
        else if (tick) tick_cnt_q <= '0;
        else           tick_cnt_q <= tick_cnt_q + 1'b1;
    end

    // Exactly one row low; x & (x-1) clears the lowest set bit of x.
    assign rs_valid = (~rs_q != 4'b0000) && (((~rs_q) & ((~rs_q) - 4'b0001)) == 4'b0000);
    assign col_rot  = {col_q[2:0], col_q[3]};
    assign cnt_inc  = cnt_q + 1'b1;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_SCAN;
            col_q   <= 4'b1110;
            pat_q   <= 4'b1111;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        pat_d      = pat_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        accept_pat = pat_q;

        if (tick) begin
            case (state_q)
                S_SCAN: begin
                    if (rs_valid) begin
                        pat_d = rs_q;
                        // With a single-tick debounce the detecting tick is
                        // already enough to accept; col stays on the key.
                        if (DEBOUNCE_TICKS == 1) begin
                            accept     = 1'b1;
                            accept_pat = rs_q;
                            cnt_d      = '0;
                            state_d    = S_HELD;
                        end else begin
                            cnt_d   = CW'(1);
                            state_d = S_DEBOUNCE;
                        end
                    end else begin
                        col_d = col_rot;
                    end
                end

                S_DEBOUNCE: begin
                    if (rs_q == pat_q) begin
                        if (cnt_inc == DB_DONE) begin
                            accept  = 1'b1;
                            cnt_d   = '0;
                            state_d = S_HELD;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d   = '0;
                        col_d   = col_rot;
                        state_d = S_SCAN;
                    end
                end

                S_HELD: begin
                    // Release must be clean for DEBOUNCE_TICKS ticks; any
                    // activity (bounce, another key) restarts the count.
                    if (rs_q == 4'b1111) begin
                        if (cnt_inc == DB_DONE) begin
                            cnt_d   = '0;
                            col_d   = col_rot;
                            state_d = S_SCAN;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end

                default: begin
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end
            endcase
        end
    end

    assign accept_code = key_lookup(accept_pat, col_q);

    // --------------------------------------------------------- entry digits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            ones_q      <= 4'h0;
            tens_q      <= 4'h0;
            hundred_q   <= 4'h0;
            thousand_q  <= 4'h0;
        end else begin
            key_valid_q <= accept;
            if (accept) begin
                key_code_q <= accept_code;
                if (accept_code <= 4'd9) begin
                    thousand_q <= hundred_q;
                    hundred_q  <= tens_q;
                    tens_q     <= ones_q;
                    ones_q     <= accept_code;
                end else if (accept_code == 4'hA) begin
                    thousand_q <= 4'h0;
                    hundred_q  <= 4'h0;
                    tens_q     <= 4'h0;
                    ones_q     <= 4'h0;
                end else if (accept_code == 4'hB) begin
                    ones_q     <= tens_q;
                    tens_q     <= hundred_q;
                    hundred_q  <= thousand_q;
                    thousand_q <= 4'h0;
                end
            end
        end
    end

    assign kp.col       = col_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.ones      = ones_q;
    assign kp.tens      = tens_q;
    assign kp.hundred   = hundred_q;
    assign kp.thousand  = thousand_q;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// -----------------------------------------------------------------------------
// tb_keypad_bcd_entry
//   Drives keypad_bcd_entry (CLK_DIV=4, DEBOUNCE_TICKS=3) through a model of
//   the physical 4x4 matrix: a closed contact at (r,c) pulls row r low while
//   column c is driven low.
// -----------------------------------------------------------------------------
module tb_keypad_bcd_entry;

    localparam int CLK_DIV        = 4;
    localparam int DEBOUNCE_TICKS = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    keypad_bcd_entry_if kp ();

    keypad_bcd_entry #(
        .CLK_DIV        (CLK_DIV),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp.master)
    );

    always #5 clk = ~clk;

    // contact[r][c] = 1 means the key at row r, column c is physically closed.
    logic [3:0][3:0] contact;

    always_comb begin
        kp.row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (contact[r][c] && !kp.col[c]) kp.row[r] = 1'b0;
    end

    // Reference tick phase: ticks fall on every CLK_DIV-th cycle after reset.
    int tb_cnt;
    logic tb_tick;
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cnt <= 0;
        else     tb_cnt <= (tb_cnt == CLK_DIV - 1) ? 0 : tb_cnt + 1;
    end
    assign tb_tick = (tb_cnt == CLK_DIV - 1);

    // Count every cycle key_valid is high.
    int vcount = 0;
    always @(posedge clk) if (kp.key_valid === 1'b1) vcount <= vcount + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] digits();
        return {kp.thousand, kp.hundred, kp.tens, kp.ones};
    endfunction

    // Returns right after the next rising edge on which the DUT ticks.
    task automatic next_tick_edge();
        @(negedge clk);
        while (!tb_tick) @(negedge clk);
        @(posedge clk);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) next_tick_edge();
    endtask

    // Waits (bounded) for key_valid; lands on a negedge after the pulse.
    task automatic wait_valid(input string name, input int bound);
        int start;
        int n;
        start = vcount;
        n = 0;
        @(negedge clk);
        while (vcount == start && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (vcount == start) begin
            errors++;
            checks++;
            $display("FAIL %s: key_valid timeout after %0d cycles", name, bound);
        end
    endtask

    typedef struct {
        int         r;
        int         c;
        logic [3:0] code;
        logic [15:0] dig;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int base;
        logic [3:0] exp_col;

        // {row, col, expected key_code, expected thousand..ones}
        vecs[0]  = '{0, 3, 4'hA, 16'h0000};
        vecs[1]  = '{0, 0, 4'h1, 16'h0001};
        vecs[2]  = '{0, 1, 4'h2, 16'h0012};
        vecs[3]  = '{0, 2, 4'h3, 16'h0123};
        vecs[4]  = '{1, 0, 4'h4, 16'h1234};
        vecs[5]  = '{1, 1, 4'h5, 16'h2345};
        vecs[6]  = '{1, 3, 4'hB, 16'h0234};
        vecs[7]  = '{0, 3, 4'hA, 16'h0000};
        vecs[8]  = '{2, 2, 4'h9, 16'h0009};
        vecs[9]  = '{3, 1, 4'h0, 16'h0090};
        vecs[10] = '{2, 0, 4'h7, 16'h0907};
        vecs[11] = '{3, 2, 4'hF, 16'h0907};
        vecs[12] = '{2, 1, 4'h8, 16'h9078};
        vecs[13] = '{2, 3, 4'hC, 16'h9078};
        vecs[14] = '{3, 3, 4'hD, 16'h9078};
        vecs[15] = '{1, 2, 4'h6, 16'h0786};
        vecs[16] = '{3, 0, 4'hE, 16'h0786};

        contact = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        check("reset col", kp.col, 4'b1110);
        check("reset key_valid", kp.key_valid, 1'b0);
        check("reset key_code", kp.key_code, 4'h0);
        check("reset digits", digits(), 16'h0000);

        @(negedge clk);
        rst = 1'b0;

        // Idle scan: one column step per tick, no key ever reported
        base = vcount;
        exp_col = 4'b1110;
        for (int i = 0; i < 8; i++) begin
            next_tick_edge();
            #1;
            exp_col = {exp_col[2:0], exp_col[3]};
            check($sformatf("idle col step %0d", i), kp.col, exp_col);
        end
        check("idle no key_valid", vcount - base, 0);
        check("idle digits", digits(), 16'h0000);

        // Key 2 held long: one pulse only
        base = vcount;
        contact[0][1] = 1'b1;
        wait_valid("key2", 200);
        check("key2 code", kp.key_code, 4'h2);
        check("key2 digits", digits(), 16'h0002);
        wait_ticks(50);
        check("key2 held pulses", vcount - base, 1);
        contact = '0;
        wait_ticks(8);
        check("key2 released pulses", vcount - base, 1);

        // Table of single key presses
        foreach (vecs[i]) begin
            base = vcount;
            contact[vecs[i].r][vecs[i].c] = 1'b1;
            wait_valid($sformatf("vec%0d", i), 200);
            check($sformatf("vec%0d code", i), kp.key_code, vecs[i].code);
            check($sformatf("vec%0d digits", i), digits(), vecs[i].dig);
            contact = '0;
            wait_ticks(8);
            check($sformatf("vec%0d pulses", i), vcount - base, 1);
        end

        // Two rows low in the same column: never accepted
        base = vcount;
        contact[0][1] = 1'b1;
        contact[1][1] = 1'b1;
        wait_ticks(40);
        check("two rows no accept", vcount - base, 0);
        check("two rows digits", digits(), 16'h0786);
        contact = '0;
        wait_ticks(8);

        // Reset asserted while in HELD
        contact[0][1] = 1'b1;
        wait_valid("pre-reset key2", 200);
        check("pre-reset digits", digits(), 16'h7862);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid reset col", kp.col, 4'b1110);
        check("mid reset key_valid", kp.key_valid, 1'b0);
        check("mid reset key_code", kp.key_code, 4'h0);
        check("mid reset digits", digits(), 16'h0000);
        @(negedge clk);
        @(negedge clk);
        base = vcount;
        rst = 1'b0;
        wait_ticks(60);
        check("held through reset pulses", vcount - base, 1);
        check("held through reset code", kp.key_code, 4'h2);
        check("held through reset digits", digits(), 16'h0002);
        contact = '0;
        wait_ticks(8);

        // Bounce: 2 good ticks, 1 open tick, then steady
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (kp.col !== 4'b1110 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("bounce reach col 1110", kp.col, 4'b1110);
        end
        base = vcount;
        contact[0][1] = 1'b1;
        next_tick_edge();             // col -> 1101
        #1;
        check("bounce col on key", kp.col, 4'b1101);
        next_tick_edge();             // detect, cnt=1
        next_tick_edge();             // cnt=2
        #1;
        contact[0][1] = 1'b0;
        next_tick_edge();             // open contact seen: abort
        #1;
        check("bounce abort col advance", kp.col, 4'b1011);
        check("bounce no early accept", vcount - base, 0);
        contact[0][1] = 1'b1;
        wait_valid("bounce accept", 200);
        check("bounce code", kp.key_code, 4'h2);
        check("bounce digits", digits(), 16'h0022);
        contact = '0;
        wait_ticks(8);
        check("bounce pulses", vcount - base, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
